beta_regfile: RTL and testbench

Parametrised multi-register storage block for the Beta datapath, generalising the single-bit D flip-flop into an array of NREGS registers of WIDTH bits each. It provides two combinational read ports and one clocked write port, with an optional hardwired-zero top register (Beta R31) and optional same-cycle write-to-read bypass. It sits between instruction decode (register addresses) and the ALU / memory-write operand paths.

---
 rtl/beta_regfile.sv | 83 ++++++++
 tb/tb_beta_regfile.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/beta_regfile.sv
// Beta register file: NREGS x WIDTH storage with two combinational read ports,
// one clocked write port, optional hardwired-zero top register and write bypass.
module beta_regfile #(
  parameter int WIDTH    = 32,
  parameter int NREGS    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    ra_addr,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data,
  input  logic             wen,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd
);

  // Registers that are neither readable nor writable (the hardwired zero).
  localparam logic [NREGS-1:0] ZERO_MASK =
    (ZERO_REG != 0) ? {1'b1, {(NREGS-1){1'b0}}} : '0;

  logic [NREGS-1:0][WIDTH-1:0] regs;
  logic [NREGS-1:0]            wr_hit;

  // One-hot decode of an address onto the accessible registers; addresses at
  // or beyond NREGS decode to no register at all, so they read 0 and never write.
  function automatic logic [NREGS-1:0] decode(input logic [AW-1:0] addr);
    logic [NREGS-1:0] hit;
    hit = '0;
    for (int i = 0; i < NREGS; i++) begin
      hit[i] = (addr == AW'(i));
    end
    return hit & ~ZERO_MASK;
  endfunction

  function automatic logic [WIDTH-1:0] read_port(
    input logic [AW-1:0]                 addr,
    input logic [NREGS-1:0][WIDTH-1:0]   regs_q,
    input logic [NREGS-1:0]              wr_sel,
    input logic [WIDTH-1:0]              wr_data
  );
    logic [NREGS-1:0] rd_hit;
    logic [WIDTH-1:0] data;
    // NOTE: every variable gets a value on every path before it is used, so
    // combinational logic built from this never holds state (no latches).
    rd_hit = decode(addr);
    data   = '0;
    if ((BYPASS != 0) && |(rd_hit & wr_sel)) begin
      data = wr_data;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        data |= {WIDTH{rd_hit[i]}} & regs_q[i];
      end
    end
    return data;
  endfunction

  // Reset wins over a concurrent write; gating here also keeps the bypass
  // from forwarding wd while reset is asserted.
  assign wr_hit = (wen && !reset) ? decode(wa) : '0;

  // NOTE: the register array is cleared by reset on purpose: software relies on
  // every register reading 0 after reset, so this storage cannot be left
  // uninitialised the way a RAM macro would be.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      // NOTE: non-blocking assignments so every register samples the same
      // pre-edge values regardless of statement order.
      if (reset) begin
        regs[i] <= '0;
      end else if (wr_hit[i]) begin
        regs[i] <= wd;
      end
    end
  end

  assign ra_data = read_port(ra_addr, regs, wr_hit, wd);
  assign rb_data = read_port(rb_addr, regs, wr_hit, wd);

endmodule

// File: tb/tb_beta_regfile.sv
// Self-checking bench for beta_regfile: four parameter configurations share one
// stimulus stream and are compared every cycle against an array-based model.
module tb_beta_regfile;

  localparam int NCFG = 4;
  localparam int NREGS_C [NCFG] = '{32, 32, 24, 24};
  localparam bit ZR_C    [NCFG] = '{1'b1, 1'b0, 1'b1, 1'b0};
  localparam bit BP_C    [NCFG] = '{1'b1, 1'b0, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        reset;
  logic        wen;
  logic [4:0]  ra_addr, rb_addr, wa;
  logic [31:0] wd;
  logic [31:0] ra_d [NCFG];
  logic [31:0] rb_d [NCFG];

  logic [31:0] mem [NCFG][32];
  bit          chk_en = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  beta_regfile #(.WIDTH(32), .NREGS(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) u_dut0 (
    .clk(clk), .reset(reset), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_d[0]), .rb_data(rb_d[0]), .wen(wen), .wa(wa), .wd(wd));
  beta_regfile #(.WIDTH(32), .NREGS(32), .AW(5), .ZERO_REG(0), .BYPASS(0)) u_dut1 (
    .clk(clk), .reset(reset), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_d[1]), .rb_data(rb_d[1]), .wen(wen), .wa(wa), .wd(wd));
  beta_regfile #(.WIDTH(32), .NREGS(24), .AW(5), .ZERO_REG(1), .BYPASS(1)) u_dut2 (
    .clk(clk), .reset(reset), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_d[2]), .rb_data(rb_d[2]), .wen(wen), .wa(wa), .wd(wd));
  beta_regfile #(.WIDTH(32), .NREGS(24), .AW(5), .ZERO_REG(0), .BYPASS(0)) u_dut3 (
    .clk(clk), .reset(reset), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_d[3]), .rb_data(rb_d[3]), .wen(wen), .wa(wa), .wd(wd));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit writable(input int c, input logic [4:0] a);
    return (int'(a) < NREGS_C[c]) && !(ZR_C[c] && int'(a) == NREGS_C[c] - 1);
  endfunction

  function automatic logic [31:0] model_read(input int c, input logic [4:0] a);
    if (int'(a) >= NREGS_C[c]) return 32'h0;
    if (ZR_C[c] && int'(a) == NREGS_C[c] - 1) return 32'h0;
    if (BP_C[c] && wen && !reset && a == wa && writable(c, wa)) return wd;
    return mem[c][a];
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < NCFG; c++) begin
      for (int r = 0; r < 32; r++) begin
        if (reset) mem[c][r] <= 32'h0;
        else if (wen && writable(c, wa) && r == int'(wa)) mem[c][r] <= wd;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < NCFG; c++) begin
        check($sformatf("cfg%0d ra@%0d", c, ra_addr), ra_d[c], model_read(c, ra_addr));
        check($sformatf("cfg%0d rb@%0d", c, rb_addr), rb_d[c], model_read(c, rb_addr));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; wen = 1'b0; wa = '0; wd = '0; ra_addr = '0; rb_addr = '0;
    step();
    reset  = 1'b0;
    chk_en = 1'b1;

    // Every address reads 0 after reset.
    for (int a = 0; a < 32; a++) begin
      ra_addr = 5'(a);
      rb_addr = 5'(31 - a);
      @(negedge clk);
      check("reset_sweep_ra", ra_d[1], 32'h0);
      step();
    end

    // Fill registers 0..30, then read everything back on both ports.
    for (int k = 0; k < 31; k++) begin
      wen = 1'b1; wa = 5'(k); wd = 32'hA5A5_0000 + k; ra_addr = 5'(k); rb_addr = 5'(k + 1);
      step();
    end
    wen = 1'b0;
    for (int k = 0; k < 32; k++) begin
      ra_addr = 5'(k); rb_addr = 5'(k);
      step();
    end
    ra_addr = 5'd3; rb_addr = 5'd30;
    @(negedge clk);
    check("readback_ra3",  ra_d[0], 32'hA5A5_0003);
    check("readback_rb30", rb_d[0], 32'hA5A5_001E);
    check("readback_ra3_cfg1", ra_d[1], 32'hA5A5_0003);
    step();

    // Hardwired zero register versus an ordinary top register.
    wen = 1'b1; wa = 5'd31; wd = 32'hFFFF_FFFF; ra_addr = 5'd31; rb_addr = 5'd31;
    @(negedge clk);
    check("zero_reg_same_cycle", ra_d[0], 32'h0);
    check("plain_r31_before",    ra_d[1], 32'h0);
    step();
    wen = 1'b0;
    @(negedge clk);
    check("zero_reg_after",  ra_d[0], 32'h0);
    check("plain_r31_after", ra_d[1], 32'hFFFF_FFFF);
    step();

    // Write bypass.
    wen = 1'b1; wa = 5'd5; wd = 32'h1111_1111; ra_addr = 5'd5; rb_addr = 5'd6;
    step();
    wd = 32'h2222_2222;
    @(negedge clk);
    check("bypass_on_before",  ra_d[0], 32'h2222_2222);
    check("bypass_off_before", ra_d[1], 32'h1111_1111);
    step();
    wen = 1'b0;
    @(negedge clk);
    check("bypass_off_after", ra_d[1], 32'h2222_2222);
    step();

    // Reset colliding with a write: reset wins, no forwarding during reset.
    reset = 1'b1; wen = 1'b1; wa = 5'd7; wd = 32'hDEAD_BEEF; ra_addr = 5'd7; rb_addr = 5'd3;
    @(negedge clk);
    check("collision_during_cfg0", ra_d[0], 32'hA5A5_0007);
    check("collision_during_cfg1", ra_d[1], 32'hA5A5_0007);
    step();
    reset = 1'b0; wen = 1'b0;
    @(negedge clk);
    check("collision_after", ra_d[0], 32'h0);
    step();

    // Random traffic with occasional resets and biased read/write collisions.
    for (int n = 0; n < 2000; n++) begin
      reset   = ($urandom_range(63) == 0);
      wen     = ($urandom_range(3) != 0);
      wa      = 5'($urandom);
      wd      = $urandom;
      ra_addr = ($urandom_range(3) == 0) ? wa : 5'($urandom);
      rb_addr = ($urandom_range(3) == 0) ? wa : 5'($urandom);
      step();
    end
    reset = 1'b0;

    // Out-of-range write on the 24-register configurations.
    wen = 1'b1; wa = 5'd28; wd = 32'h0000_1234; ra_addr = 5'd28; rb_addr = 5'd28;
    @(negedge clk);
    check("oor_read_cfg2",   ra_d[2], 32'h0);
    check("oor_read_cfg3",   ra_d[3], 32'h0);
    check("inrange_bypass",  ra_d[0], 32'h0000_1234);
    step();
    wen = 1'b0;
    @(negedge clk);
    check("oor_after_cfg3", ra_d[3], 32'h0);
    step();
    for (int a = 0; a < 32; a++) begin
      ra_addr = 5'(a); rb_addr = 5'(a);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
